// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Streams a program image, one byte at a time, into word-wide memory.
//   Stream format (big-endian): 4-byte word count, then count data words, then
//   (checksum build only) a 4-byte checksum equal to the mod-2^32 sum of the
//   data words. Each completed data word produces a single-cycle WORD write.
//   The CPU is held (cpuHold=1) everywhere except after a successful load.
//
// Optional feature: define LOADER_CHECKSUM_EN to add the trailing checksum
//   check (state CHK). Without it the last write (or count=0) goes to DONE.
//
// Parameters
//   BASE_ADDR  byte address of the first loaded word
//   MAX_WORDS  largest accepted word count (larger counts abort the load)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      pulse that begins a load session (honoured in IDLE/DONE/ERROR)
//   byteData   incoming program byte
//   byteValid  byteData is valid; held until byteReady accepts it
//   byteReady  loader accepts a byte this cycle
//   address    memory write address (holds last value outside WRITE)
//   data       memory write data    (holds last value outside WRITE)
//   writeMode  MemoryModesPackage encoding: NONE=3'd0, WORD=3'd3
//   cpuHold    holds the CPU/PC stage while memory is being loaded
//   done       load completed successfully (held until next start)
//   error      load aborted (held until next start)
// -----------------------------------------------------------------------------
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byteData,
  input  logic        byteValid,
  output logic        byteReady,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic [2:0]  writeMode,
  output logic        cpuHold,
  output logic        done,
  output logic        error
);

  localparam logic [2:0]  MODE_NONE = 3'd0;
  localparam logic [2:0]  MODE_WORD = 3'd3;
  localparam logic [31:0] MAX_W     = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once all data words are written (or count=0).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_FINISH = S_CHK;
`else
  localparam state_t S_FINISH = S_DONE;
`endif

  state_t      r_state;
  state_t      w_next;
  logic [23:0] r_shift;     // first three bytes of the word being assembled
  logic [1:0]  r_bcnt;      // bytes already accepted for the current word
  logic [31:0] r_index;
  logic [31:0] r_count;
  logic [31:0] r_address;
  logic [31:0] r_data;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
`endif

  logic        w_ready;
  logic        w_accept;
  logic        w_last_byte;
  logic [31:0] w_word;
  logic [31:0] w_index_inc;
  logic        w_restart;

  // byteReady depends on state only, so a pending byte simply waits.
  always_comb begin
    w_ready = (r_state == S_LEN) || (r_state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    if (r_state == S_CHK) w_ready = 1'b1;
`endif
  end

  assign byteReady   = w_ready;
  assign w_accept    = byteValid & w_ready;
  assign w_last_byte = w_accept && (r_bcnt == 2'd3);
  assign w_word      = {r_shift, byteData};
  assign w_index_inc = r_index + 32'd1;
  assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERROR));

  assign address = r_address;
  assign data    = r_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    writeMode = MODE_NONE;
    cpuHold   = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_last_byte) begin
          if (w_word == 32'd0)     w_next = S_FINISH;
          else if (w_word > MAX_W) w_next = S_ERROR;
          else                     w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: begin
        writeMode = MODE_WORD;
        // r_index still holds the index of the word being written here.
        if (w_index_inc == r_count) w_next = S_FINISH;
        else                        w_next = S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_last_byte) w_next = (w_word == r_sum) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        cpuHold = 1'b0;
        done    = 1'b1;
        if (start) w_next = S_LEN;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) w_next = S_LEN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_index   <= '0;
      r_count   <= '0;
      r_address <= '0;
      r_data    <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      if (w_restart) begin
        r_index <= '0;
        r_bcnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= '0;
`endif
      end
      // r_bcnt wraps 3->0 on its own, so each 4-byte field starts fresh.
      if (w_accept) begin
        r_bcnt  <= r_bcnt + 2'd1;
        r_shift <= {r_shift[15:0], byteData};
      end
      if (w_last_byte && (r_state == S_LEN)) r_count <= w_word;
      if (w_last_byte && (r_state == S_DATA)) begin
        r_address <= BASE_ADDR + {r_index[29:0], 2'b00};
        r_data    <= w_word;
      end
      if (r_state == S_WRITE) begin
        r_index <= w_index_inc;
`ifdef LOADER_CHECKSUM_EN
        r_sum   <= r_sum + r_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic [31:0] address;
  logic [31:0] data;
  logic [2:0]  writeMode;
  logic        cpuHold;
  logic        done;
  logic        error;

  program_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(16384)) dut (
    .clk(clk), .rst(rst), .start(start),
    .byteData(byteData), .byteValid(byteValid), .byteReady(byteReady),
    .address(address), .data(data), .writeMode(writeMode),
    .cpuHold(cpuHold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every WORD write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && (writeMode !== 3'd0)) begin
      check("write_mode", {29'd0, writeMode}, 32'd3);
      check("ready_in_write", {31'd0, byteReady}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", address, data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", address, mon_e.a);
        check("write_data", data, mon_e.d);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_mode"},  {29'd0, writeMode}, 32'd0);
    check({tag, "_addr"},  address, 32'd0);
    check({tag, "_data"},  data, 32'd0);
    check({tag, "_ready"}, {31'd0, byteReady}, 32'd0);
    check({tag, "_hold"},  {31'd0, cpuHold}, 32'd1);
    check({tag, "_done"},  {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present a byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    byteData  = b;
    byteValid = 1'b1;
    t = 0;
    while (!byteReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept_timeout: got byteReady=0 for 50 cycles expected 1");
    end
    @(negedge clk);
    if (gap) begin
      byteValid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8],  gap);
    send_byte(w[7:0],   gap);
  endtask

  task automatic wait_end(input string tag);
    int t;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done/error expected one within 20 cycles", tag);
    end
  endtask

  task automatic check_end(input string tag, input bit exp_done);
    check({tag, "_done"},  {31'd0, done},    {31'd0, exp_done});
    check({tag, "_error"}, {31'd0, error},   {31'd0, !exp_done});
    check({tag, "_hold"},  {31'd0, cpuHold}, {31'd0, !exp_done});
    check({tag, "_qempty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b1;
    @(negedge clk);
    check("idle_hold", {31'd0, cpuHold}, 32'd1);

    // Basic load with idle cycles between bytes.
    exp_q.push_back('{a: 32'h0000_0000, d: 32'h1234_5678});
    exp_q.push_back('{a: 32'h0000_0004, d: 32'hA1B2_C3D4});
    pulse_start();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h1234_5678, 1'b1);
    send_word(32'hA1B2_C3D4, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hB3E7_1A4C, 1'b1);
`endif
    wait_end("basic");
    check_end("basic", 1'b1);
    repeat (3) @(negedge clk);
    check("basic_done_held", {31'd0, done}, 32'd1);

    // Backpressure: byteValid stays high across WRITE cycles.
    exp_q.push_back('{a: 32'h0000_0000, d: 32'h1234_5678});
    exp_q.push_back('{a: 32'h0000_0004, d: 32'hA1B2_C3D4});
    pulse_start();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'hA1B2_C3D4, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'hB3E7_1A4C, 1'b0);
`endif
    byteValid = 1'b0;
    wait_end("bp");
    check_end("bp", 1'b1);

    // Overlength count: 16385 > 16384.
    pulse_start();
    send_word(32'h0000_4001, 1'b1);
    wait_end("overlen");
    check_end("overlen", 1'b0);
    repeat (3) @(negedge clk);
    check("overlen_err_held", {31'd0, error}, 32'd1);

    // Reset in the middle of word 2: only word 1 is written.
    exp_q.push_back('{a: 32'h0000_0000, d: 32'hCAFE_F00D});
    pulse_start();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'hCAFE_F00D, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    byteValid = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    check("midrst_qempty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    exp_q.push_back('{a: 32'h0000_0000, d: 32'h1122_3344});
    exp_q.push_back('{a: 32'h0000_0004, d: 32'h5566_7788});
    pulse_start();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h1122_3344, 1'b1);
    send_word(32'h5566_7788, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h6688_AACC, 1'b1);
`endif
    wait_end("reload");
    check_end("reload", 1'b1);

    // Zero-length load.
    pulse_start();
    send_word(32'h0000_0000, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_word(32'h0000_0000, 1'b1);
`endif
    wait_end("zero");
    check_end("zero", 1'b1);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch; writes happen either way.
    exp_q.push_back('{a: 32'h0000_0000, d: 32'h0000_0001});
    exp_q.push_back('{a: 32'h0000_0004, d: 32'h0000_0002});
    pulse_start();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0000_0003, 1'b1);
    wait_end("chk_ok");
    check_end("chk_ok", 1'b1);
    exp_q.push_back('{a: 32'h0000_0000, d: 32'h0000_0001});
    exp_q.push_back('{a: 32'h0000_0004, d: 32'h0000_0002});
    pulse_start();
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0000_0001, 1'b1);
    send_word(32'h0000_0002, 1'b1);
    send_word(32'h0000_0004, 1'b1);
    wait_end("chk_bad");
    check_end("chk_bad", 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd0: byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 16384: largest accepted word count.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: pulse that begins a load session.
REQ-006 SHALL have port byteData, input, 8 bits: incoming program byte.
REQ-007 SHALL have port byteValid, input, 1 bit: byteData is valid.
REQ-008 SHALL have port byteReady, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port address, output, 32 bits: memory write address.
REQ-010 SHALL have port data, output, 32 bits: memory write data.
REQ-011 SHALL have port writeMode, output, 3 bits: MemoryModesPackage encoding; only NONE or WORD is driven.
REQ-012 SHALL have port cpuHold, output, 1 bit: holds the CPU/PC stage while low-level memory is being loaded.
REQ-013 SHALL have port done, output, 1 bit: load completed successfully.
REQ-014 SHALL have port error, output, 1 bit: load aborted.

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, WRITE, CHK (REQ-031 only), DONE, ERROR.
REQ-016 SHALL accept a byte only on a rising edge where byteValid and byteReady are both 1.
REQ-017 SHALL drive byteReady=1 in LEN, DATA and CHK; 0 in IDLE, WRITE, DONE and ERROR.
REQ-018 SHALL assemble words big-endian: the first byte accepted becomes bits [31:24] and the fourth becomes bits [7:0].
REQ-019 SHALL move from IDLE, DONE or ERROR to LEN on start=1, clearing the word index, byte counter, done and error; start SHALL be ignored in LEN, DATA, WRITE and CHK.
REQ-020 SHALL, in LEN, latch the fourth byte's assembled word as count: count=0 goes to DONE (CHK if enabled); count>MAX_WORDS goes to ERROR; otherwise to DATA.
REQ-021 SHALL, on the fourth byte of a word in DATA, enter WRITE for exactly one cycle with writeMode=WORD, address=BASE_ADDR+4*index (32-bit modulo wrap), and data=the assembled word.
REQ-022 SHALL, after WRITE, increment index; index==count goes to DONE (CHK if enabled); otherwise back to DATA.
REQ-023 SHALL drive writeMode=NONE in every state other than WRITE; address and data SHALL hold their last values.
REQ-024 SHALL drive cpuHold=1 in every state except DONE, and done=1 only in DONE.
REQ-025 SHALL drive error=1 only in ERROR; ERROR and DONE are held until start.
REQ-026 SHALL never lose a byte: a byte presented while byteReady=0 stays pending until it is accepted.

Reset
REQ-027 SHALL, while rst=0, immediately force state=IDLE, writeMode=NONE, address=0, data=0, byteReady=0, cpuHold=1, done=0, error=0, and clear the index, count, byte counter and checksum.
REQ-028 SHALL discard any partial word on reset mid-operation and issue no write for it.

Configuration
REQ-029 SHALL compile the checksum feature in only when macro LOADER_CHECKSUM_EN is defined.
REQ-030 SHALL, without LOADER_CHECKSUM_EN, omit state CHK; the last WRITE (or count=0) goes directly to DONE.
REQ-031 SHALL, with LOADER_CHECKSUM_EN, keep a running 32-bit sum (mod 2^32) of the data words, then collect 4 further bytes in CHK: a match goes to DONE, a mismatch to ERROR; writes already issued are not undone.

Verification
REQ-032 SHALL cover a basic load: reset, start, bytes 00 00 00 02 12 34 56 78 A1 B2 C3 D4 -> one-cycle WORD writes (0, 12345678h) and (4, A1B2C3D4h), then done=1, cpuHold=0.
REQ-033 SHALL cover backpressure: the same stream with byteValid held continuously high -> byteReady=0 in each WRITE cycle, identical writes, no bytes lost or duplicated.
REQ-034 SHALL cover overlength: count bytes 00 00 40 01 with MAX_WORDS=16384 -> error=1, cpuHold=1, no WORD write.
REQ-035 SHALL cover reset mid-word: rst=0 after 2 bytes of word 2 -> all outputs at reset values, no write; a subsequent full load completes with done=1.
REQ-036 SHALL cover zero length: bytes 00 00 00 00 -> done=1 with no write (checksum 00000000 required if enabled).
REQ-037 SHALL cover the checksum (LOADER_CHECKSUM_EN): words 00000001 and 00000002 with checksum 00000003 -> done=1; the same words with checksum 00000004 -> error=1, both writes still observed.
